// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order word reads to instruction memory and
// buffers returned words with their addresses in a prefetch queue for the decoder.
module instr_fetch_unit #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     dec_valid,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam int                PW      = $clog2(DEPTH);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]       DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   q_pc_q [DEPTH];
    logic [31:0]   q_pc_d [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_instr_d [DEPTH];

    logic [CW-1:0] live_s;
    logic [CW:0]   credit_s;
    logic          grant_s;
    logic          rsp_s;
    logic          push_s;
    logic          pop_s;

    // Credit: queued words plus live reads must stay below DEPTH so the queue never overflows.
    always_comb begin
        live_s   = outstanding_q - drop_cnt_q;
        credit_s = {1'b0, count_q} + {1'b0, live_s};
        imem_req = !rst && !redirect_valid && (credit_s < DEPTH_W) && (outstanding_q < DEPTH_C);
        grant_s  = imem_req && imem_gnt;
        rsp_s    = imem_rvalid && (outstanding_q != '0);
        push_s   = rsp_s && (drop_cnt_q == '0) && !redirect_valid;
        pop_s    = dec_ready && (count_q != '0);
    end

    assign imem_addr = fetch_pc_q;
    assign dec_valid = (count_q != '0);
    assign dec_instr = q_instr_q[rd_ptr_q];
    assign dec_pc    = q_pc_q[rd_ptr_q];
    assign fq_count  = count_q;

    // Next-state: a redirect flushes the queue and marks every unreturned read stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(grant_s) - CW'(rsp_s);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            drop_cnt_d = outstanding_q + CW'(grant_s) - CW'(rsp_s);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (grant_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_s && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (push_s) begin
                q_pc_d[wr_ptr_q]    = resp_pc_q;
                q_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d            = wr_ptr_q + PW'(1);
                resp_pc_d           = resp_pc_q + 32'd4;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers; reset also clears queue storage so the decoder outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_ADDR;
            resp_pc_q     <= RESET_ADDR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= 32'h0000_0000;
                q_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            q_pc_q        <= q_pc_d;
            q_instr_q     <= q_instr_d;
        end
    end

endmodule
